// File: rtl/fifo_sync_block.sv
// Synchronous single-clock FIFO with registered read data, fill-level
// accounting, programmable almost-full/almost-empty flags and optional
// sticky overflow/underflow error flags.
//
// Build option: define FIFO_SYNC_ERR_FLAG_EN to enable the sticky
// overflow_o/underflow_o flags and the err_clear_i input. Without it both
// flags are tied low and err_clear_i is ignored.
//
// Handshake: a write is accepted on a rising edge when write_en_i=1 and
// full_o=0; a read is accepted when read_en_i=1 and empty_o=0. An accepted
// read presents its word on data_o with data_valid_o=1 for exactly the one
// cycle following the accepting edge. Requests are levels, not held
// transactions: a rejected request is simply dropped.
module fifo_sync_block #(
  parameter int data_size = 8,
  parameter int addr_size = 3
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 write_en_i,
  input  logic [data_size-1:0] data_i,
  input  logic                 read_en_i,
  input  logic [addr_size:0]   almost_full_thresh_i,
  input  logic [addr_size:0]   almost_empty_thresh_i,
  input  logic                 err_clear_i,
  output logic [data_size-1:0] data_o,
  output logic                 data_valid_o,
  output logic [addr_size:0]   fill_level_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  localparam int depth = 2 ** addr_size;

  // Count value meaning "every slot occupied": only the MSB of the
  // addr_size+1 bit counter is set.
  localparam logic [addr_size:0] depth_c = {1'b1, {addr_size{1'b0}}};

  // Storage array; contents are not reset, only the pointers and count.
  logic [data_size-1:0] mem_q [depth];

  logic [addr_size-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_size-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_size:0]   count_q,  count_d;
  logic [data_size-1:0] data_q,   data_d;
  logic                 valid_q,  valid_d;

  logic full_w;
  logic empty_w;
  logic wr_accept;
  logic rd_accept;

  // Status flags come straight from the registered count so they never
  // depend on the current cycle's requests.
  always_comb begin
    full_w         = (count_q == depth_c);
    empty_w        = (count_q == '0);
    almost_full_o  = (count_q >= almost_full_thresh_i);
    almost_empty_o = (count_q <= almost_empty_thresh_i);
  end

  // Request qualification: at full a simultaneous read still goes through
  // (freeing a slot next cycle) but the write is dropped; at empty the
  // write goes through and the read is dropped, so there is no fall-through.
  always_comb begin
    wr_accept = write_en_i & ~full_w;
    rd_accept = read_en_i & ~empty_w;
  end

  // Next-state for pointers, count and the registered read port.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = 1'b0;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      data_d   = mem_q[rd_ptr_q];
      valid_d  = 1'b1;
    end

    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control and read-port registers, asynchronously cleared.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  // Storage write; only accepted writes touch the array.
  always_ff @(posedge clock_i) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

`ifdef FIFO_SYNC_ERR_FLAG_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags: a set event in the same cycle wins over a clear.
  // Overflow is any write request while full, even if a simultaneous read
  // is accepted; underflow is any read request while empty.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clear_i) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (write_en_i && full_w) begin
      overflow_d = 1'b1;
    end
    if (read_en_i && empty_w) begin
      underflow_d = 1'b1;
    end
  end

  // Error flag registers, asynchronously cleared.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`else
  // Error flags disabled: outputs are constant and the clear is unused.
  logic unused_err_clear;
  assign unused_err_clear = err_clear_i;
  assign overflow_o       = 1'b0;
  assign underflow_o      = 1'b0;
`endif

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign fill_level_o = count_q;
  assign full_o       = full_w;
  assign empty_o      = empty_w;

endmodule

// File: tb/tb_fifo_sync_block.sv
// Self-checking bench for fifo_sync_block (data_size=8, addr_size=3).
// Directed vectors drive requests; a reference model tracks contents,
// level and error flags; accepted reads push the expected word and its
// expected arrival cycle into a queue that a negedge monitor drains.
module tb_fifo_sync_block;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

`ifdef FIFO_SYNC_ERR_FLAG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clock_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          write_en_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          read_en_i = 1'b0;
  logic [AW:0]   af_th = '0;
  logic [AW:0]   ae_th = '0;
  logic          err_clear_i = 1'b0;
  logic [DW-1:0] data_o;
  logic          data_valid_o;
  logic [AW:0]   fill_level_o;
  logic          full_o, empty_o, almost_full_o, almost_empty_o;
  logic          overflow_o, underflow_o;

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  fifo_sync_block #(.data_size(DW), .addr_size(AW)) dut (
    .clock_i               (clock_i),
    .reset_i               (reset_i),
    .write_en_i            (write_en_i),
    .data_i                (data_i),
    .read_en_i             (read_en_i),
    .almost_full_thresh_i  (af_th),
    .almost_empty_thresh_i (ae_th),
    .err_clear_i           (err_clear_i),
    .data_o                (data_o),
    .data_valid_o          (data_valid_o),
    .fill_level_o          (fill_level_o),
    .full_o                (full_o),
    .empty_o               (empty_o),
    .almost_full_o         (almost_full_o),
    .almost_empty_o        (almost_empty_o),
    .overflow_o            (overflow_o),
    .underflow_o           (underflow_o)
  );

  // ---------------- model / scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_dout = '0;
  bit            model_ovf = 1'b0;
  bit            model_unf = 1'b0;
  bit            last_rd_ok = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    int lvl;
    lvl = model_q.size();
    check({tag, ".fill"},   32'(fill_level_o),   32'(lvl));
    check({tag, ".empty"},  32'(empty_o),        32'(lvl == 0));
    check({tag, ".full"},   32'(full_o),         32'(lvl == DEPTH));
    check({tag, ".afull"},  32'(almost_full_o),  32'(lvl >= int'(af_th)));
    check({tag, ".aempty"}, 32'(almost_empty_o), 32'(lvl <= int'(ae_th)));
    check({tag, ".dout"},   32'(data_o),         32'(model_dout));
    check({tag, ".valid"},  32'(data_valid_o),   32'(last_rd_ok));
    check({tag, ".ovf"},    32'(overflow_o),     32'(model_ovf));
    check({tag, ".unf"},    32'(underflow_o),    32'(model_unf));
  endtask

  // ---------------- driver ----------------
  task automatic do_cycle(input string tag, input bit we, input logic [DW-1:0] d,
                          input bit re, input bit clr);
    int lvl;
    bit wr_ok, rd_ok;
    @(negedge clock_i);
    write_en_i  = we;
    data_i      = d;
    read_en_i   = re;
    err_clear_i = clr;
    lvl   = model_q.size();
    wr_ok = we && (lvl != DEPTH);
    rd_ok = re && (lvl != 0);
    if (ERR_EN) begin
      if (clr) begin
        model_ovf = 1'b0;
        model_unf = 1'b0;
      end
      if (we && lvl == DEPTH) model_ovf = 1'b1;
      if (re && lvl == 0)     model_unf = 1'b1;
    end
    if (rd_ok) begin
      model_dout = model_q.pop_front();
      exp_q.push_back(model_dout);
      exp_cyc_q.push_back(cyc + 1);
    end
    if (wr_ok) model_q.push_back(d);
    last_rd_ok = rd_ok;
    @(posedge clock_i);
    #1;
    write_en_i  = 1'b0;
    read_en_i   = 1'b0;
    err_clear_i = 1'b0;
    check_status(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle("idle", 1'b0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock_i) begin
    if (reset_i === 1'b0 && data_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: got data 0x%0h with valid, expected no read (t=%0t)", data_o, $time);
      end else begin
        logic [DW-1:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("rd_data", 32'(data_o), 32'(e));
        check("rd_latency_cycle", 32'(cyc), 32'(ec));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset with almost-full threshold 0: almost_full must read 1.
    af_th = 4'd0;
    ae_th = 4'd2;
    #1 reset_i = 1'b1;
    #1;
    check_status("reset");
    check("reset.afull_thresh0", 32'(almost_full_o), 32'd1);
    check("reset.aempty", 32'(almost_empty_o), 32'd1);
    // Threshold change takes effect without a clock edge.
    af_th = 4'd6;
    #1;
    check("thresh_same_cycle", 32'(almost_full_o), 32'd0);
    // Write request at an edge while reset is still high is ignored.
    @(negedge clock_i);
    write_en_i = 1'b1;
    data_i     = 8'h55;
    @(posedge clock_i);
    #1;
    check("reset_edge_write_ignored", 32'(fill_level_o), 32'd0);
    @(negedge clock_i);
    write_en_i = 1'b0;
    reset_i    = 1'b0;

    // Fill 0x11..0x18, reject 9th write, drain in order.
    for (int i = 0; i < 8; i++) do_cycle("fill", 1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
    check("fill_level_full", 32'(fill_level_o), 32'd8);
    check("full_flag", 32'(full_o), 32'd1);
    do_cycle("wr_at_full", 1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf_after_9th", 32'(overflow_o), 32'(ERR_EN));
    check("fill_still_8", 32'(fill_level_o), 32'd8);
    for (int i = 0; i < 8; i++) do_cycle("drain", 1'b0, '0, 1'b1, 1'b0);
    check("drained_empty", 32'(empty_o), 32'd1);
    check("last_word", 32'(data_o), 32'h18);

    // Underflow, clear, and set-beats-clear.
    do_cycle("rd_at_empty", 1'b0, '0, 1'b1, 1'b0);
    check("unf_set", 32'(underflow_o), 32'(ERR_EN));
    check("unf_no_valid", 32'(data_valid_o), 32'd0);
    idle(1);
    check("dout_held", 32'(data_o), 32'h18);
    do_cycle("err_clear", 1'b0, '0, 1'b0, 1'b1);
    check("unf_cleared", 32'(underflow_o), 32'd0);
    check("ovf_cleared", 32'(overflow_o), 32'd0);
    do_cycle("set_and_clear", 1'b0, '0, 1'b1, 1'b1);
    check("unf_set_wins", 32'(underflow_o), 32'(ERR_EN));
    do_cycle("err_clear2", 1'b0, '0, 1'b0, 1'b1);

    // Almost flags: AF=6, AE=2.
    for (int i = 0; i < 6; i++) begin
      do_cycle("thresh_fill", 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
      if (i == 2) check("aempty_fell_after_3rd", 32'(almost_empty_o), 32'd0);
      if (i == 4) check("afull_low_after_5th", 32'(almost_full_o), 32'd0);
    end
    check("afull_rose_after_6th", 32'(almost_full_o), 32'd1);
    for (int i = 0; i < 6; i++) do_cycle("thresh_drain", 1'b0, '0, 1'b1, 1'b0);

    // Level 4 plus 20 cycles of simultaneous read+write (pointers wrap).
    for (int i = 0; i < 4; i++) do_cycle("fill4", 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) do_cycle("rw_steady", 1'b1, 8'hB0 + 8'(i), 1'b1, 1'b0);
    check("steady_level_4", 32'(fill_level_o), 32'd4);
    for (int i = 0; i < 4; i++) do_cycle("drain4", 1'b0, '0, 1'b1, 1'b0);

    // Full with simultaneous read+write: read wins, write dropped.
    for (int i = 0; i < 8; i++) do_cycle("fill8", 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    do_cycle("rw_at_full", 1'b1, 8'hEE, 1'b1, 1'b0);
    check("rw_full_level_7", 32'(fill_level_o), 32'd7);
    check("rw_full_ovf", 32'(overflow_o), 32'(ERR_EN));
    for (int i = 0; i < 7; i++) do_cycle("drain7", 1'b0, '0, 1'b1, 1'b0);
    do_cycle("err_clear3", 1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset mid-burst at level 5.
    for (int i = 0; i < 5; i++) do_cycle("pre_reset", 1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
    do_cycle("pre_reset_rd", 1'b0, '0, 1'b1, 1'b0);
    do_cycle("pre_reset_wr", 1'b1, 8'hD5, 1'b0, 1'b0);
    @(negedge clock_i);
    write_en_i = 1'b1;
    data_i     = 8'h77;
    #2 reset_i = 1'b1;
    #1;
    model_q.delete();
    model_dout = '0;
    model_ovf  = 1'b0;
    model_unf  = 1'b0;
    last_rd_ok = 1'b0;
    check("async_rst.fill", 32'(fill_level_o), 32'd0);
    check("async_rst.dout", 32'(data_o), 32'd0);
    check("async_rst.empty", 32'(empty_o), 32'd1);
    check_status("async_rst");
    @(posedge clock_i);
    #1;
    check("rst_held_write_ignored", 32'(fill_level_o), 32'd0);
    @(negedge clock_i);
    write_en_i = 1'b0;
    reset_i    = 1'b0;
    do_cycle("rd_after_reset", 1'b0, '0, 1'b1, 1'b0);
    check("rd_after_reset_rejected", 32'(data_valid_o), 32'd0);

    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
